// File: rtl/ip_ram_fifo_dump.sv
// ip_ram_fifo_dump: debug read initiator that walks a window of FIFO RAM over the CPU read port and streams the words out
// Ports:
//   clockCore, resetCore          core clock, asynchronous active-high reset
//   start, startAddress, dumpLength, abort   dump command (address/length sampled with start)
//   cpuReadValid, cpuReadAddress, cpuReadAck, cpuReadData   read request/ack to the FIFO controller
//   dumpValid, dumpReady, dumpData, dumpLast   valid/ready output stream
//   busy, done, timeoutErr, wordsDumped   status
module ip_ram_fifo_dump #(
  parameter int DEPTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  parameter int TIMEOUT = 16
) (
  input  logic                 clockCore,
  input  logic                 resetCore,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] startAddress,
  input  logic [ADDRWIDTH:0]   dumpLength,
  input  logic                 abort,
  output logic                 cpuReadValid,
  output logic [ADDRWIDTH-1:0] cpuReadAddress,
  input  logic                 cpuReadAck,
  input  logic [DATAWIDTH-1:0] cpuReadData,
  output logic                 dumpValid,
  input  logic                 dumpReady,
  output logic [DATAWIDTH-1:0] dumpData,
  output logic                 dumpLast,
  output logic                 busy,
  output logic                 done,
  output logic                 timeoutErr,
  output logic [ADDRWIDTH:0]   wordsDumped
);
  localparam int LENWIDTH = ADDRWIDTH + 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} stateType;
  stateType state, stateNext;
  logic [LENWIDTH-1:0] remaining, lengthClamped;
  logic [ADDRWIDTH-1:0] addressStart;
  logic [7:0] waitCount;
  logic accept, aborting, ackTaken, timedOut, handshake;
  always_comb begin
    lengthClamped = (dumpLength > LENWIDTH'(DEPTH)) ? LENWIDTH'(DEPTH) : dumpLength;
    addressStart = ({1'b0, startAddress} >= LENWIDTH'(DEPTH)) ? '0 : startAddress;
    busy = state == REQ || state == WAIT || state == DRAIN;
    done = state == DONE;
    cpuReadValid = state == REQ;
    // DONE is not busy, so a new dump may be launched in the same cycle as the done pulse
    accept = start && !busy;
    aborting = abort && busy;
    // abort wins over a coincident ack so a discarded word never reaches the stream
    ackTaken = state == REQ && cpuReadAck && !abort;
    timedOut = state == REQ && !cpuReadAck && !abort && waitCount == 8'(TIMEOUT - 1);
    handshake = dumpValid && dumpReady;
    stateNext = state;
    case (state)
      IDLE, DONE: stateNext = accept ? (lengthClamped == '0 ? DONE : REQ) : IDLE;
      REQ:        stateNext = (abort || timedOut) ? DONE : cpuReadAck ? (remaining > LENWIDTH'(1) ? WAIT : DRAIN) : REQ;
      WAIT:       stateNext = abort ? DONE : (!dumpValid || dumpReady) ? REQ : WAIT;
      DRAIN:      stateNext = (abort || handshake) ? DONE : DRAIN;
      default:    stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      state <= IDLE;
      cpuReadAddress <= '0;
      remaining <= '0;
      waitCount <= '0;
      dumpValid <= 1'b0;
      dumpData <= '0;
      dumpLast <= 1'b0;
      timeoutErr <= 1'b0;
      wordsDumped <= '0;
    end else begin
      state <= stateNext;
      // every REQ visit is preceded by a non-REQ cycle, so this clears on REQ entry
      waitCount <= (state == REQ) ? waitCount + 8'd1 : '0;
      if (accept) begin
        cpuReadAddress <= addressStart;
        remaining <= lengthClamped;
        timeoutErr <= 1'b0;
        wordsDumped <= '0;
      end
      if (timedOut) timeoutErr <= 1'b1;
      if (handshake) begin
        dumpValid <= 1'b0;
        dumpLast <= 1'b0;
        wordsDumped <= wordsDumped + 1'b1;
      end
      if (ackTaken) begin
        dumpData <= cpuReadData;
        dumpValid <= 1'b1;
        dumpLast <= remaining == LENWIDTH'(1);
        remaining <= remaining - 1'b1;
        cpuReadAddress <= (cpuReadAddress == ADDRWIDTH'(DEPTH - 1)) ? '0 : cpuReadAddress + 1'b1;
      end
      if (aborting) begin
        dumpValid <= 1'b0;
        dumpLast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ip_ram_fifo_dump.sv
// tb_ip_ram_fifo_dump: scoreboard bench for ip_ram_fifo_dump with a RAM-backed read responder
module tb_ip_ram_fifo_dump;
  localparam int DEPTH = 32, DW = 32, AW = 5, LW = 6, TIMEOUT = 16;
  logic clockCore = 0, resetCore = 0, start = 0, abort = 0, cpuReadAck = 0, dumpReady = 1;
  logic [AW-1:0] startAddress = '0;
  logic [LW-1:0] dumpLength = '0;
  logic [DW-1:0] cpuReadData = '0;
  logic cpuReadValid, dumpValid, dumpLast, busy, done, timeoutErr;
  logic [AW-1:0] cpuReadAddress;
  logic [DW-1:0] dumpData;
  logic [LW-1:0] wordsDumped;
  int tests = 0, fails = 0, cyc = 0, doneCount = 0, expDone = 0;
  logic [DW-1:0] ram [DEPTH];
  int expAddr[$];
  logic [DW:0] expWord[$];
  int hsCyc[$];
  bit respEn = 1, respRandom = 0, forceAck = 0, reqSeen = 0, prevAck = 0, held = 0;
  logic [DW-1:0] heldData;
  logic heldLast;
  logic [DW:0] w;

  ip_ram_fifo_dump #(.DEPTH(DEPTH), .DATAWIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clockCore(clockCore), .resetCore(resetCore), .start(start), .startAddress(startAddress),
    .dumpLength(dumpLength), .abort(abort), .cpuReadValid(cpuReadValid), .cpuReadAddress(cpuReadAddress),
    .cpuReadAck(cpuReadAck), .cpuReadData(cpuReadData), .dumpValid(dumpValid), .dumpReady(dumpReady),
    .dumpData(dumpData), .dumpLast(dumpLast), .busy(busy), .done(done), .timeoutErr(timeoutErr),
    .wordsDumped(wordsDumped));

  always #5 clockCore = ~clockCore;
  always @(posedge clockCore) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // responder: acks one cycle after it sees a request, never twice in a row, optionally stalling
  always @(negedge clockCore) reqSeen = cpuReadValid;
  always @(posedge clockCore) begin
    #1;
    cpuReadAck = forceAck || (respEn && reqSeen && !cpuReadAck && (!respRandom || $urandom_range(0, 3) != 0));
    cpuReadData = (cpuReadAck && !forceAck) ? ram[cpuReadAddress] : $urandom;
  end

  // monitor: request addresses, stream words, stability and done pulses
  always @(negedge clockCore) begin
    if (!resetCore) begin
      if (done) doneCount++;
      if (prevAck) check("valid after ack", cpuReadValid, 0);
      if (cpuReadAck && cpuReadValid) begin
        if (expAddr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected request: actual addr %0d required none", cpuReadAddress);
        end else check("request addr", cpuReadAddress, expAddr.pop_front());
      end
      if (held && dumpValid) begin
        check("data stable", dumpData, heldData);
        check("last stable", dumpLast, heldLast);
      end
      if (dumpValid && !dumpReady) check("request while holding", cpuReadValid, 0);
      if (dumpValid && dumpReady) begin
        hsCyc.push_back(cyc);
        if (expWord.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected word: actual %0h last %0b required none", dumpData, dumpLast);
        end else begin
          w = expWord.pop_front();
          check("dump data", dumpData, w[DW:1]);
          check("dump last", dumpLast, w[0]);
        end
      end
    end
    prevAck = cpuReadAck;
    held = dumpValid && !dumpReady;
    heldData = dumpData;
    heldLast = dumpLast;
  end

  function automatic int pushExp(input int sa, input int len);
    int eff = len > DEPTH ? DEPTH : len;
    int a0 = sa >= DEPTH ? 0 : sa;
    for (int i = 0; i < eff; i++) begin
      int a = (a0 + i) % DEPTH;
      expAddr.push_back(a);
      expWord.push_back({ram[a], i == eff - 1});
    end
    return eff;
  endfunction

  task automatic issue(input int sa, input int len, input bit ab, output int c0);
    @(posedge clockCore); #1;
    startAddress = AW'(sa);
    dumpLength = LW'(len);
    start = 1;
    abort = ab;
    c0 = cyc;
    @(posedge clockCore); #1;
    start = 0;
    abort = 0;
  endtask

  // rdyMode: 0 ready always, 1 random ready, 2 ready dropped for 10 cycles after the first word
  task automatic waitDone(input int rdyMode, input bit inj, output int doneCyc, output int vcyc);
    int bp = 0;
    bit first = 0, got = 0;
    vcyc = 0;
    doneCyc = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clockCore);
      if (cpuReadValid) vcyc++;
      if (done) begin got = 1; doneCyc = cyc; break; end
      if (rdyMode == 2 && !first && dumpValid) begin first = 1; bp = 10; end
      @(posedge clockCore); #1;
      dumpReady = rdyMode == 1 ? 1'($urandom_range(0, 1)) : (bp > 0 ? 1'b0 : 1'b1);
      if (bp > 0) bp--;
      start = inj && n == 3;
    end
    start = 0;
    dumpReady = 1;
    if (!got) begin
      tests++; fails++;
      $display("FAIL done wait: actual no done in 600 cycles required done pulse");
    end
  endtask

  initial begin
    int eff, c0, dc, vc;
    logic [DW-1:0] keep;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    #1 resetCore = 1;
    @(negedge clockCore);
    check("reset outputs", {cpuReadValid, cpuReadAddress, dumpValid, dumpData, dumpLast, busy, done, timeoutErr, wordsDumped}, 0);
    @(posedge clockCore); #1 resetCore = 0;

    hsCyc.delete();
    eff = pushExp(0, 4);
    issue(0, 4, 0, c0);
    @(negedge clockCore);
    check("cycle1 busy", busy, 1);
    check("cycle1 request", cpuReadValid, 1);
    waitDone(0, 0, dc, vc);
    expDone++;
    check("basic words", wordsDumped, eff);
    check("basic handshakes", hsCyc.size(), 4);
    if (hsCyc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("basic word cycle", hsCyc[i], c0 + 3 + 3 * i);
      check("basic done cycle", dc, hsCyc[3] + 1);
    end
    check("busy at done", busy, 0);

    eff = pushExp(30, 4);
    issue(30, 4, 0, c0);
    waitDone(0, 0, dc, vc);
    expDone++;
    check("wrap words", wordsDumped, eff);

    eff = pushExp(3, 40);
    issue(3, 40, 0, c0);
    waitDone(0, 0, dc, vc);
    expDone++;
    check("clamp words", wordsDumped, 32);

    eff = pushExp(5, 5);
    issue(5, 5, 0, c0);
    waitDone(2, 0, dc, vc);
    expDone++;
    check("backpressure words", wordsDumped, eff);

    // zero-length dump, then a start accepted in its done cycle
    @(posedge clockCore); #1;
    startAddress = '0; dumpLength = '0; start = 1; c0 = cyc;
    @(posedge clockCore); #1;
    eff = pushExp(9, 3);
    startAddress = 5'd9; dumpLength = 6'd3;
    @(negedge clockCore);
    check("zero len done", done, 1);
    check("zero len no request", cpuReadValid, 0);
    check("zero len busy", busy, 0);
    expDone += 2;
    @(posedge clockCore); #1;
    start = 0;
    hsCyc.delete();
    waitDone(0, 0, dc, vc);
    check("start in done words", wordsDumped, eff);
    if (hsCyc.size() > 0) check("start in done first word cycle", hsCyc[0], c0 + 4);

    eff = pushExp(10, 3);
    issue(10, 3, 0, c0);
    startAddress = 5'd7; dumpLength = 6'd1;
    waitDone(0, 1, dc, vc);
    expDone++;
    check("start while busy words", wordsDumped, eff);

    eff = pushExp(20, 2);
    issue(20, 2, 1, c0);
    waitDone(0, 0, dc, vc);
    expDone++;
    check("start with abort words", wordsDumped, eff);

    respEn = 0;
    issue(3, 4, 0, c0);
    waitDone(0, 0, dc, vc);
    expDone++;
    check("timeout valid cycles", vc, TIMEOUT);
    check("timeout done cycle", dc, c0 + TIMEOUT + 1);
    check("timeout flag", timeoutErr, 1);
    check("timeout words", wordsDumped, 0);
    repeat (5) @(negedge clockCore);
    check("timeout sticky", timeoutErr, 1);
    issue(0, 0, 0, c0);
    @(negedge clockCore);
    expDone++;
    check("restart done", done, 1);
    check("restart clears timeout", timeoutErr, 0);

    keep = dumpData;
    issue(4, 5, 0, c0);
    @(negedge clockCore);
    check("abort pre request", cpuReadValid, 1);
    @(posedge clockCore); #1 abort = 1;
    @(negedge clockCore) forceAck = 1;
    @(posedge clockCore); #1 abort = 0;
    @(negedge clockCore);
    forceAck = 0;
    expDone++;
    check("abort done", done, 1);
    check("abort request dropped", cpuReadValid, 0);
    check("abort timeout unchanged", timeoutErr, 0);
    @(negedge clockCore);
    check("stray ack words", wordsDumped, 0);
    check("stray ack valid", dumpValid, 0);
    check("stray ack data", dumpData, keep);
    respEn = 1;

    dumpReady = 0;
    expAddr.push_back(12);
    issue(12, 1, 0, c0);
    for (int n = 0; n < 50 && !dumpValid; n++) @(negedge clockCore);
    check("drain word held", dumpValid, 1);
    @(posedge clockCore); #1 abort = 1;
    @(posedge clockCore); #1 abort = 0;
    @(negedge clockCore);
    expDone++;
    check("drain abort valid", dumpValid, 0);
    check("drain abort last", dumpLast, 0);
    check("drain abort done", done, 1);
    dumpReady = 1;

    respRandom = 1;
    for (int k = 0; k < 20; k++) begin
      int sa = $urandom_range(0, DEPTH - 1);
      int len = $urandom_range(0, 40);
      eff = pushExp(sa, len);
      issue(sa, len, 0, c0);
      waitDone(1, 0, dc, vc);
      expDone++;
      check("random words", wordsDumped, eff);
    end
    respRandom = 0;

    dumpReady = 0;
    eff = pushExp(0, 4);
    issue(0, 4, 0, c0);
    for (int n = 0; n < 50 && !dumpValid; n++) @(negedge clockCore);
    check("reset pre valid", dumpValid, 1);
    #1 resetCore = 1;
    #1;
    check("async reset outputs", {cpuReadValid, cpuReadAddress, dumpValid, dumpData, dumpLast, busy, done, timeoutErr, wordsDumped}, 0);
    expAddr.delete();
    expWord.delete();
    repeat (3) @(posedge clockCore);
    #1 resetCore = 0;
    dumpReady = 1;
    eff = pushExp(17, 2);
    issue(17, 2, 0, c0);
    waitDone(0, 0, dc, vc);
    expDone++;
    check("after reset words", wordsDumped, eff);

    repeat (3) @(negedge clockCore);
    check("queues drained", expWord.size() + expAddr.size(), 0);
    check("done pulses", doneCount, expDone);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ip_ram_fifo_dump.md
# ip_ram_fifo_dump

Debug read initiator for the CPU read port of the RAM-backed FIFO controller. On a start command it walks a window of FIFO RAM addresses, with wrap-around, issuing cpuReadValid/cpuReadAddress requests and collecting cpuReadAck/cpuReadData. Each word is delivered on a valid/ready stream with a last marker. It sits between the FIFO controller's CPU port and the register/debug logic that drains dumps to the host.

## Interface
- DEPTH, 32, FIFO RAM depth in words; addresses wrap at DEPTH-1.
- DATAWIDTH, 32, RAM word width.
- ADDRWIDTH, derived ceil(log2(DEPTH)), minimum 1, same ladder as the FIFO controller; lengths use ADDRWIDTH+1 bits.
- TIMEOUT, 16, cycles to wait for cpuReadAck before aborting; range 2..255.
- clockCore  input  1  core clock, all logic on rising edge.
- resetCore  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle dump command; ignored while busy=1.
- startAddress  input  ADDRWIDTH  first RAM address, sampled with start; values ≥DEPTH are reduced to 0.
- dumpLength  input  ADDRWIDTH+1  words to dump, sampled with start; 0 means none; values >DEPTH are clamped to DEPTH.
- abort  input  1  terminate the current dump.
- cpuReadValid  output  1  read request to the FIFO controller.
- cpuReadAddress  output  ADDRWIDTH  request address; stable while cpuReadValid=1.
- cpuReadAck  input  1  one-cycle acknowledge; cpuReadData is valid in the same cycle.
- cpuReadData  input  DATAWIDTH  read data.
- dumpValid  output  1  stream word valid.
- dumpReady  input  1  stream consumer ready.
- dumpData  output  DATAWIDTH  stream word.
- dumpLast  output  1  marks the final word of the dump.
- busy  output  1  a dump is in progress; the owner must not pop the FIFO while busy=1.
- done  output  1  one-cycle pulse at the end of every dump, whether normal, aborted, timed out or zero-length.
- timeoutErr  output  1  sticky flag; cleared by an accepted start.
- wordsDumped  output  ADDRWIDTH+1  count of stream handshakes in the current or last dump.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE: busy=0. An accepted start latches the address and the clamped length, clears timeoutErr and clears wordsDumped.
  - If the clamped length is 0, go to DONE.
  - Otherwise go to REQ.
- REQ: cpuReadValid=1 and cpuReadAddress=current address, both registered.
  - The timeout counter clears on REQ entry and counts each REQ cycle.
  - On cpuReadAck: capture cpuReadData into the output register and set dumpValid=1. Set dumpLast=1 if remaining=1. Decrement remaining. Advance the address (DEPTH-1 wraps to 0). Go to WAIT if remaining was >1, else go to DRAIN.
  - If the counter reaches TIMEOUT with no ack: set timeoutErr=1, capture nothing, go to DONE.
- WAIT: cpuReadValid=0. Go to REQ when the output register is empty or is being emptied this cycle (dumpValid & dumpReady).
- DRAIN: cpuReadValid=0. Go to DONE on the handshake of the last word.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then go to IDLE.
- Stream: dumpValid stays high until dumpReady. dumpData and dumpLast stay stable while dumpValid & !dumpReady. wordsDumped increments on each handshake.
- abort in REQ, WAIT or DRAIN:
  - Drop cpuReadValid and dumpValid next cycle.
  - Discard any unsent word; dumpLast is never emitted.
  - Go to DONE. timeoutErr is unchanged.
  - abort in IDLE or DONE has no effect.
- An ack arriving outside REQ (a stray ack after an abort or timeout) is ignored and does not change data or counters.
- start and abort in the same cycle in IDLE: start is accepted and abort is ignored.

## Timing
- Reset values:
  - cpuReadValid=0, cpuReadAddress=0.
  - dumpValid=0, dumpData=0, dumpLast=0.
  - busy=0, done=0, timeoutErr=0, wordsDumped=0.
  - State is IDLE.
- Cycle numbering with start at cycle 0:
  - busy=1 and cpuReadValid=1 from cycle 1.
  - With a responder that acks one cycle after valid, the ack arrives at cycle 2 and dumpValid=1 at cycle 3.
- Cycles per word with dumpReady held at 1:
  - The ack cycle is followed by one WAIT cycle, then REQ.
  - Steady state is 3 cycles per word: valid, ack, gap.
  - cpuReadValid is never high in the cycle after an ack. This guarantees the toggling-ack responder never double-acks.
- Last-word timing: the last handshake is at cycle t, done pulses at t+1, busy=0 from t+1, and a new start is accepted at t+1.
- Zero-length timing: start at cycle 0 gives done at cycle 1, with no cpuReadValid and no stream word.
- Timeout timing: cpuReadValid is high for exactly TIMEOUT cycles, timeoutErr=1 and done=1 in the next cycle, and timeoutErr holds until the next accepted start.
- Asynchronous reset mid-dump: all outputs return immediately to their reset values, with no done pulse.

## Test plan
- Reset: assert resetCore mid-dump with dumpValid=1 -> all outputs go to reset values without waiting for a clock edge; after release, the state is IDLE and start works.
- Basic dump: startAddress=0, dumpLength=4, ack-next-cycle responder, dumpReady=1 -> addresses 0,1,2,3; data matches RAM; dumpLast only on the 4th word; wordsDumped=4; done one cycle after the last handshake; 3-cycle spacing.
- Wrap and clamp (DEPTH=32):
  - startAddress=30, dumpLength=4 -> addresses 30,31,0,1.
  - dumpLength=40 -> exactly 32 words.
- Backpressure: dumpReady=0 for 10 cycles after the first word -> dumpData/dumpLast stable, cpuReadValid stays 0, no words lost or duplicated, and the dump resumes when dumpReady=1.
- Timeout: the responder never acks -> cpuReadValid high 16 cycles, then timeoutErr=1 and a done pulse, with no stream word. A following start clears timeoutErr.
- Abort and edge cases:
  - abort during REQ -> the stray ack is ignored, done pulses, dumpLast is never seen.
  - dumpLength=0 -> done at cycle 1 with no request.
  - start while busy -> ignored.
